uart_byte_rx: RTL and testbench

//  RS-232 byte receiver, 8N1, LSB first; the receive side of our byte transmitter.

---
 rtl/uart_defs_pkg.sv | 38 +++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_byte_rx.sv | 148 ++++++++++++++
 tb/tb_uart_byte_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: baud terminal counts, frame bit levels and the RX FSM encoding.
package uart_defs;

  localparam logic [15:0] BpsDr9600   = 16'd5207;
  localparam logic [15:0] BpsDr19200  = 16'd2603;
  localparam logic [15:0] BpsDr38400  = 16'd1301;
  localparam logic [15:0] BpsDr57600  = 16'd867;
  localparam logic [15:0] BpsDr115200 = 16'd433;

  localparam int unsigned DBG_DR_DEFAULT = 5;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } rx_state_e;

  // Bit-period terminal count; one bit lasts the returned value plus one clocks.
  function automatic logic [15:0] bps_lookup(input logic [2:0]  baud,
                                             input logic        dbg,
                                             input logic [15:0] dbg_dr);
    logic [15:0] dr;
    case (baud)
      3'd0:    dr = BpsDr9600;
      3'd1:    dr = BpsDr19200;
      3'd2:    dr = BpsDr38400;
      3'd3:    dr = BpsDr57600;
      3'd4:    dr = dbg ? dbg_dr : BpsDr115200;
      default: dr = BpsDr9600;
    endcase
    return dr;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line synchroniser with a falling-edge detect on the synchronised value.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic [SYNC_STAGES:0]   vld_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      vld_q     <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= sync_q[SYNC_STAGES-1];
      vld_q     <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // The reset-time 1s in the chain must not fake a start edge when the line is low at release.
  assign rx_sync_o = sync_q[SYNC_STAGES-1];
  assign fall_o    = vld_q[SYNC_STAGES] & rx_prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: start-bit validation, 3-sample majority vote per bit, done/error strobes.
module uart_byte_rx
  import uart_defs::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DBG_DR      = DBG_DR_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       debug_mode,
  input  logic [2:0] baud_set,
  input  logic       Rs232_Rx,
  output logic [7:0] data_byte,
  output logic       Rx_Done,
  output logic       Frame_Err,
  output logic       uart_state
);

  logic rx_sync;
  logic start_edge;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .rx_i     (Rs232_Rx),
    .rx_sync_o(rx_sync),
    .fall_o   (start_edge)
  );

  rx_state_e   state_q, state_d;
  logic [15:0] bps_dr_q, bps_dr_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  samp_q, samp_d;
  logic [7:0]  data_byte_q, data_byte_d;
  logic        rx_done_q, rx_done_d;
  logic        frame_err_q, frame_err_d;
  logic        uart_state_q, uart_state_d;

  logic [15:0] mid;
  logic        is_wrap;
  logic        is_vote;
  logic        vote;

  assign mid     = bps_dr_q >> 1;
  assign is_wrap = (div_cnt_q == bps_dr_q);
  assign is_vote = (div_cnt_q == mid + 16'd1);
  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync) | (samp_q[1] & rx_sync);

  always_comb begin
    state_d      = state_q;
    bps_dr_d     = bps_dr_q;
    div_cnt_d    = div_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    samp_d       = samp_q;
    data_byte_d  = data_byte_q;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    uart_state_d = uart_state_q;

    if (state_q != StIdle) begin
      div_cnt_d = is_wrap ? 16'd0 : div_cnt_q + 16'd1;
      if (div_cnt_q == mid - 16'd1) samp_d[0] = rx_sync;
      if (div_cnt_q == mid)         samp_d[1] = rx_sync;
    end

    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d      = StStart;
          uart_state_d = 1'b1;
          bit_idx_d    = 3'd0;
          div_cnt_d    = 16'd0;
          bps_dr_d     = bps_lookup(baud_set, debug_mode, 16'(DBG_DR));
        end
      end
      StStart: begin
        if (is_vote && (vote != START_BIT)) begin
          state_d      = StIdle;
          uart_state_d = 1'b0;
        end else if (is_wrap) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (is_vote) shift_d = {vote, shift_q[7:1]};
        if (is_wrap) begin
          if (bit_idx_q == 3'd7) state_d = StStop;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StStop: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (is_vote) begin
          state_d      = StIdle;
          uart_state_d = 1'b0;
          if (vote == STOP_BIT) begin
            rx_done_d   = 1'b1;
            data_byte_d = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d      = StIdle;
        uart_state_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= StIdle;
      bps_dr_q     <= BpsDr9600;
      div_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      samp_q       <= '0;
      data_byte_q  <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      uart_state_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bps_dr_q     <= bps_dr_d;
      div_cnt_q    <= div_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      samp_q       <= samp_d;
      data_byte_q  <= data_byte_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      uart_state_q <= uart_state_d;
    end
  end

  assign data_byte  = data_byte_q;
  assign Rx_Done    = rx_done_q;
  assign Frame_Err  = frame_err_q;
  assign uart_state = uart_state_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: bit-banged 8N1 frames with hand-computed expectations.
module tb_uart_byte_rx;

  logic       Clk;
  logic       Rst_n;
  logic       debug_mode;
  logic [2:0] baud_set;
  logic       Rs232_Rx;
  logic [7:0] data_byte;
  logic       Rx_Done;
  logic       Frame_Err;
  logic       uart_state;

  uart_byte_rx #(
    .SYNC_STAGES(2),
    .DBG_DR     (5)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .debug_mode(debug_mode),
    .baud_set  (baud_set),
    .Rs232_Rx  (Rs232_Rx),
    .data_byte (data_byte),
    .Rx_Done   (Rx_Done),
    .Frame_Err (Frame_Err),
    .uart_state(uart_state)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  int         done_cnt;
  int         err_cnt;
  int         both_cnt;
  int         done_busy;
  bit         saw_busy;
  logic [7:0] byte_log [0:7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    done_cnt  = 0;
    err_cnt   = 0;
    both_cnt  = 0;
    done_busy = 0;
    saw_busy  = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (Rx_Done) begin
      if (done_cnt < 8) byte_log[done_cnt] = data_byte;
      done_cnt++;
      if (uart_state) done_busy++;
    end
    if (Frame_Err) err_cnt++;
    if (Rx_Done && Frame_Err) both_cnt++;
    if (uart_state) saw_busy = 1'b1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Drives the first nbits of a frame (10 = full frame). spike_bit injects a one-clock
  // inverted pulse at offset 217 of that frame bit, which lines up with div_cnt==mid at 434 clk/bit.
  task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_val,
                            input int nbits, input int spike_bit);
    logic v;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = stop_val;
      else             v = b[i-1];
      if (i == spike_bit) begin
        Rs232_Rx = v;  idle(217);
        Rs232_Rx = ~v; idle(1);
        Rs232_Rx = v;  idle(cpb - 218);
      end else begin
        Rs232_Rx = v;
        idle(cpb);
      end
    end
  endtask

  initial begin
    Rst_n      = 1'b0;
    debug_mode = 1'b1;
    baud_set   = 3'd4;
    Rs232_Rx   = 1'b1;
    clear_mon();
    #5;
    check("reset data_byte", 32'(data_byte), 32'h00);
    check("reset Rx_Done", 32'(Rx_Done), 32'h0);
    check("reset Frame_Err", 32'(Frame_Err), 32'h0);
    check("reset uart_state", 32'(uart_state), 32'h0);
    idle(3);
    Rst_n = 1'b1;
    idle(10);

    // 1: debug rate, 6 clk/bit
    clear_mon();
    send_frame(8'hA5, 6, 1'b1, 10, -1);
    idle(10);
    check("t1 done count", 32'(done_cnt), 32'd1);
    check("t1 byte", 32'(byte_log[0]), 32'hA5);
    check("t1 data_byte held", 32'(data_byte), 32'hA5);
    check("t1 frame_err", 32'(err_cnt), 32'd0);
    check("t1 busy at done", 32'(done_busy), 32'd0);

    // 2: 115200 back-to-back frames
    debug_mode = 1'b0;
    clear_mon();
    send_frame(8'h00, 434, 1'b1, 10, -1);
    send_frame(8'hFF, 434, 1'b1, 10, -1);
    send_frame(8'h55, 434, 1'b1, 10, -1);
    idle(20);
    check("t2 done count", 32'(done_cnt), 32'd3);
    check("t2 byte0", 32'(byte_log[0]), 32'h00);
    check("t2 byte1", 32'(byte_log[1]), 32'hFF);
    check("t2 byte2", 32'(byte_log[2]), 32'h55);
    check("t2 frame_err", 32'(err_cnt), 32'd0);

    // 3: short low glitch is rejected by the start-bit vote
    clear_mon();
    Rs232_Rx = 1'b0;
    idle(3);
    Rs232_Rx = 1'b1;
    idle(500);
    check("t3 saw busy", 32'(saw_busy), 32'd1);
    check("t3 back idle", 32'(uart_state), 32'd0);
    check("t3 done count", 32'(done_cnt), 32'd0);
    check("t3 err count", 32'(err_cnt), 32'd0);

    // 4: low stop bit, line held low, then a good frame
    debug_mode = 1'b1;
    clear_mon();
    send_frame(8'h3C, 6, 1'b0, 10, -1);
    idle(30);
    Rs232_Rx = 1'b1;
    idle(20);
    check("t4 err count", 32'(err_cnt), 32'd1);
    check("t4 no done", 32'(done_cnt), 32'd0);
    check("t4 data_byte kept", 32'(data_byte), 32'h55);
    check("t4 idle after break", 32'(uart_state), 32'd0);
    clear_mon();
    send_frame(8'h81, 6, 1'b1, 10, -1);
    idle(10);
    check("t4 next done", 32'(done_cnt), 32'd1);
    check("t4 next byte", 32'(byte_log[0]), 32'h81);
    check("t4 next err", 32'(err_cnt), 32'd0);

    // 5: spike in data bit 3 outvoted; mid-frame rate change ignored
    debug_mode = 1'b0;
    clear_mon();
    send_frame(8'h00, 434, 1'b1, 10, 4);
    idle(20);
    check("t5 spike done", 32'(done_cnt), 32'd1);
    check("t5 spike byte", 32'(byte_log[0]), 32'h00);
    clear_mon();
    fork
      send_frame(8'hC3, 434, 1'b1, 10, -1);
      begin
        idle(1100);
        baud_set = 3'd0;
      end
    join
    idle(20);
    baud_set = 3'd4;
    check("t5 baud switch done", 32'(done_cnt), 32'd1);
    check("t5 baud switch byte", 32'(byte_log[0]), 32'hC3);
    check("t5 baud switch err", 32'(err_cnt), 32'd0);

    // 6: reset during data bit 5 with the line low, release while still low
    debug_mode = 1'b1;
    clear_mon();
    send_frame(8'hFF, 6, 1'b1, 6, -1);
    Rs232_Rx = 1'b0;
    idle(3);
    check("t6 busy before reset", 32'(uart_state), 32'd1);
    Rst_n = 1'b0;
    #1;
    check("t6 reset data_byte", 32'(data_byte), 32'h00);
    check("t6 reset Rx_Done", 32'(Rx_Done), 32'h0);
    check("t6 reset Frame_Err", 32'(Frame_Err), 32'h0);
    check("t6 reset uart_state", 32'(uart_state), 32'h0);
    idle(5);
    Rst_n = 1'b1;
    idle(20);
    check("t6 no start on low line", 32'(uart_state), 32'd0);
    Rs232_Rx = 1'b1;
    idle(10);
    check("t6 no strobes", 32'(done_cnt + err_cnt), 32'd0);
    clear_mon();
    send_frame(8'h5A, 6, 1'b1, 10, -1);
    idle(10);
    check("t6 next done", 32'(done_cnt), 32'd1);
    check("t6 next byte", 32'(byte_log[0]), 32'h5A);
    check("t6 done/err overlap", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
